sc_ifetch: RTL and testbench

//   Instruction-fetch stage feeding the single-cycle control unit and datapath.

---
 rtl/sc_ifetch.sv | 127 ++++++++++++
 tb/tb_sc_ifetch.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sc_ifetch.sv
// Instruction-fetch stage: holds the PC, fetches the word at PC over a req/ack
// memory port and presents it to decode until the core advances to the next PC.
module sc_ifetch #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          IMEM_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [31:0] ra,
    input  logic        advance,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        fetch_err
);

    localparam int CW = (IMEM_TIMEOUT < 2) ? 1 : $clog2(IMEM_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(IMEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_VALID = 2'd1,
        S_ERR   = 2'd2
    } state_t;

    state_t        state_reg;
    logic [31:0]   pc_reg;
    logic [31:0]   inst_reg;
    logic          valid_reg;
    logic          req_reg;
    logic          err_reg;
    logic [CW-1:0] wait_cnt_reg;

    logic [31:0]   pc4_next;
    logic [31:0]   pc_next;
    logic          jr_misaligned;

    assign pc4_next      = pc_reg + 32'd4;
    assign jr_misaligned = (pcsource == 2'b10) && (ra[1:0] != 2'b00);

    always_comb begin
        pc_next = pc4_next;
        case (pcsource)
            2'b01:   pc_next = bpc;
            2'b10:   pc_next = ra;
            2'b11:   pc_next = jpc;
            default: pc_next = pc4_next;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= S_REQ;
            pc_reg       <= RESET_PC;
            inst_reg     <= 32'h0;
            valid_reg    <= 1'b0;
            req_reg      <= 1'b0;
            err_reg      <= 1'b0;
            wait_cnt_reg <= '0;
        end else begin
            case (state_reg)
                S_REQ: begin
                    // An ack only counts once the registered request is visible.
                    if (req_reg && imem_ack) begin
                        inst_reg     <= imem_rdata;
                        valid_reg    <= 1'b1;
                        req_reg      <= 1'b0;
                        wait_cnt_reg <= '0;
                        state_reg    <= S_VALID;
                    end else begin
                        req_reg <= 1'b1;
                        if (req_reg) begin
                            if (wait_cnt_reg == CNT_LAST) begin
                                err_reg      <= 1'b1;
                                req_reg      <= 1'b0;
                                wait_cnt_reg <= '0;
                                state_reg    <= S_ERR;
                            end else begin
                                wait_cnt_reg <= wait_cnt_reg + 1'b1;
                            end
                        end
                    end
                end
                S_VALID: begin
                    if (advance) begin
                        valid_reg <= 1'b0;
                        if (jr_misaligned) begin
                            err_reg   <= 1'b1;
                            state_reg <= S_ERR;
                        end else begin
                            pc_reg    <= pc_next;
                            req_reg   <= 1'b1;
                            state_reg <= S_REQ;
                        end
                    end
                end
                S_ERR: begin
                    req_reg   <= 1'b0;
                    valid_reg <= 1'b0;
                end
                default: begin
                    req_reg   <= 1'b0;
                    valid_reg <= 1'b0;
                    err_reg   <= 1'b1;
                    state_reg <= S_ERR;
                end
            endcase
        end
    end

    assign pc         = pc_reg;
    assign pc4        = pc4_next;
    assign inst       = inst_reg;
    assign inst_valid = valid_reg;
    assign imem_req   = req_reg;
    assign imem_addr  = pc_reg;
    assign fetch_err  = err_reg;

endmodule

// File: tb/tb_sc_ifetch.sv
// Self-checking bench for sc_ifetch: directed scenarios plus a randomized
// fetch/advance stream compared against a PC-level reference model.
module tb_sc_ifetch;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] bpc = 32'h0, jpc = 32'h0, ra = 32'h0;
    logic        advance = 1'b0;
    logic [31:0] pc, pc4, inst, imem_addr;
    logic        inst_valid, imem_req, fetch_err;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;

    int checks = 0;
    int passed = 0;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] exp_inst = 32'h0;

    sc_ifetch #(.RESET_PC(32'h0000_0000), .IMEM_TIMEOUT(4)) dut (
        .clock(clock), .resetn(resetn), .pcsource(pcsource), .bpc(bpc), .jpc(jpc),
        .ra(ra), .advance(advance), .pc(pc), .pc4(pc4), .inst(inst),
        .inst_valid(inst_valid), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .fetch_err(fetch_err)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Reference next-PC rule, straight from the pcsource table.
    function automatic logic [31:0] model_next(input logic [1:0] src, input logic [31:0] cur,
                                               input logic [31:0] b, input logic [31:0] j,
                                               input logic [31:0] r);
        case (src)
            2'b00:   return cur + 32'd4;
            2'b01:   return b;
            2'b10:   return r;
            default: return j;
        endcase
    endfunction

    task automatic apply_reset();
        resetn = 1'b0;
        imem_ack = 1'b0;
        advance = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) $display("FAIL rst_req: imem_req=%b required 0", imem_req); else passed++;
        checks++; if (inst_valid !== 1'b0) $display("FAIL rst_valid: inst_valid=%b required 0", inst_valid); else passed++;
        checks++; if (inst !== 32'h0) $display("FAIL rst_inst: inst=%h required 0", inst); else passed++;
        checks++; if (pc !== 32'h0 || imem_addr !== 32'h0) $display("FAIL rst_pc: pc=%h addr=%h required 0", pc, imem_addr); else passed++;
        checks++; if (fetch_err !== 1'b0) $display("FAIL rst_err: fetch_err=%b required 0", fetch_err); else passed++;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        exp_pc = 32'h0;
        exp_inst = 32'h0;
    endtask

    // Wait for a request, answer it after lat no-ack cycles, check the presented word.
    task automatic fetch_word(input int lat, input logic [31:0] word, input string tag);
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 10) begin
            @(negedge clock);
            n++;
        end
        checks++; if (imem_req !== 1'b1) $display("FAIL %s_req: imem_req=%b required 1", tag, imem_req); else passed++;
        checks++; if (imem_addr !== exp_pc) $display("FAIL %s_addr: imem_addr=%h required %h", tag, imem_addr, exp_pc); else passed++;
        for (int i = 0; i < lat; i++) begin
            @(negedge clock);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== exp_pc || inst_valid !== 1'b0)
                $display("FAIL %s_wait: req=%b addr=%h valid=%b required 1/%h/0", tag, imem_req, imem_addr, inst_valid, exp_pc);
            else passed++;
        end
        imem_ack = 1'b1;
        imem_rdata = word;
        @(negedge clock);
        imem_ack = 1'b0;
        imem_rdata = $urandom;
        exp_inst = word;
        checks++; if (inst_valid !== 1'b1) $display("FAIL %s_valid: inst_valid=%b required 1", tag, inst_valid); else passed++;
        checks++; if (inst !== word) $display("FAIL %s_inst: inst=%h required %h", tag, inst, word); else passed++;
        checks++; if (pc !== exp_pc) $display("FAIL %s_pc: pc=%h required %h", tag, pc, exp_pc); else passed++;
        checks++; if (pc4 !== exp_pc + 32'd4) $display("FAIL %s_pc4: pc4=%h required %h", tag, pc4, exp_pc + 32'd4); else passed++;
        checks++; if (imem_req !== 1'b0) $display("FAIL %s_reqlow: imem_req=%b required 0", tag, imem_req); else passed++;
        $display("fetch %s pc=%h inst=%h lat=%0d", tag, pc, inst, lat);
    endtask

    // Hold in S_VALID for some cycles, then pulse advance with an aligned target.
    task automatic do_advance(input logic [1:0] src, input logic [31:0] b, input logic [31:0] j,
                              input logic [31:0] r, input int hold, input string tag);
        for (int i = 0; i < hold; i++) begin
            imem_ack = ($urandom_range(0, 1) == 1);
            @(negedge clock);
            checks++;
            if (inst_valid !== 1'b1 || imem_req !== 1'b0 || pc !== exp_pc || inst !== exp_inst)
                $display("FAIL %s_hold: valid=%b req=%b pc=%h inst=%h required 1/0/%h/%h", tag, inst_valid, imem_req, pc, inst, exp_pc, exp_inst);
            else passed++;
        end
        imem_ack = 1'b0;
        pcsource = src; bpc = b; jpc = j; ra = r;
        advance = 1'b1;
        @(negedge clock);
        advance = 1'b0;
        exp_pc = model_next(src, exp_pc, b, j, r);
        checks++; if (inst_valid !== 1'b0) $display("FAIL %s_adv_valid: inst_valid=%b required 0", tag, inst_valid); else passed++;
        checks++; if (pc !== exp_pc) $display("FAIL %s_adv_pc: pc=%h required %h", tag, pc, exp_pc); else passed++;
        checks++; if (fetch_err !== 1'b0) $display("FAIL %s_adv_err: fetch_err=%b required 0", tag, fetch_err); else passed++;
        $display("advance %s src=%0d next_pc=%h", tag, src, exp_pc);
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_first_fetch();
        fetch_word(2, 32'h2001_0005, "first");
    endtask

    task automatic test_pcsource();
        do_advance(2'b00, 32'h0, 32'h0, 32'h0, 1, "seq");
        fetch_word(1, 32'h1111_0001, "seq");
        do_advance(2'b01, 32'h40, 32'h0, 32'h0, 0, "br");
        fetch_word(0, 32'h1111_0002, "br");
        do_advance(2'b11, 32'h0, 32'h100, 32'h0, 2, "jmp");
        fetch_word(3, 32'h1111_0003, "jmp");
        do_advance(2'b10, 32'h0, 32'h0, 32'h80, 0, "jr");
        fetch_word(1, 32'h1111_0004, "jr");
    endtask

    task automatic test_misaligned_jr();
        pcsource = 2'b10; ra = 32'h82; advance = 1'b1;
        @(negedge clock);
        advance = 1'b0;
        checks++; if (fetch_err !== 1'b1) $display("FAIL jr_err: fetch_err=%b required 1", fetch_err); else passed++;
        checks++; if (pc !== exp_pc) $display("FAIL jr_pc: pc=%h required %h", pc, exp_pc); else passed++;
        checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) $display("FAIL jr_req: req=%b valid=%b required 0/0", imem_req, inst_valid); else passed++;
        for (int i = 0; i < 3; i++) begin
            imem_ack = 1'b1; imem_rdata = 32'hBAD0_0000 + i; advance = 1'b1; pcsource = 2'b00;
            @(negedge clock);
            checks++;
            if (fetch_err !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0 || pc !== exp_pc)
                $display("FAIL jr_stuck: err=%b req=%b valid=%b pc=%h required 1/0/0/%h", fetch_err, imem_req, inst_valid, pc, exp_pc);
            else passed++;
        end
        imem_ack = 1'b0; advance = 1'b0;
        $display("misaligned jr ra=%h err=%b", ra, fetch_err);
    endtask

    task automatic test_timeout();
        int req_cycles;
        apply_reset();
        req_cycles = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (imem_req === 1'b1) req_cycles++;
            if (fetch_err === 1'b1) break;
        end
        checks++; if (req_cycles != 4) $display("FAIL tmo_cycles: req_cycles=%0d required 4", req_cycles); else passed++;
        checks++; if (fetch_err !== 1'b1) $display("FAIL tmo_err: fetch_err=%b required 1", fetch_err); else passed++;
        checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) $display("FAIL tmo_req: req=%b valid=%b required 0/0", imem_req, inst_valid); else passed++;
        $display("timeout req_cycles=%0d err=%b", req_cycles, fetch_err);
    endtask

    task automatic test_reset_mid_fetch();
        apply_reset();
        fetch_word(0, 32'h0000_1234, "pre");
        do_advance(2'b01, 32'h200, 32'h0, 32'h0, 0, "pre");
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #2 resetn = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) $display("FAIL mid_async: req=%b valid=%b required 0/0", imem_req, inst_valid); else passed++;
        checks++; if (pc !== 32'h0 || inst !== 32'h0) $display("FAIL mid_pc: pc=%h inst=%h required 0/0", pc, inst); else passed++;
        @(negedge clock);
        checks++; if (inst !== 32'h0 || inst_valid !== 1'b0) $display("FAIL mid_nocap: inst=%h valid=%b required 0/0", inst, inst_valid); else passed++;
        resetn = 1'b1;
        exp_pc = 32'h0;
        @(negedge clock);
        imem_ack = 1'b0;
        checks++; if (imem_req !== 1'b1 || inst_valid !== 1'b0 || inst !== 32'h0 || pc !== 32'h0)
            $display("FAIL mid_stray: req=%b valid=%b inst=%h pc=%h required 1/0/0/0", imem_req, inst_valid, inst, pc);
        else passed++;
        $display("reset mid fetch pc=%h req=%b", pc, imem_req);
        fetch_word(1, 32'h0000_5678, "post");
    endtask

    task automatic test_wrap();
        do_advance(2'b11, 32'h0, 32'hFFFF_FFFC, 32'h0, 0, "wrapj");
        fetch_word(0, 32'hCAFE_0001, "wraphi");
        do_advance(2'b00, 32'h0, 32'h0, 32'h0, 1, "wrap");
        advance = 1'b1; pcsource = 2'b01; bpc = 32'h500;
        @(negedge clock);
        advance = 1'b0;
        checks++; if (pc !== 32'h0 || inst_valid !== 1'b0) $display("FAIL wrap_ignadv: pc=%h valid=%b required 0/0", pc, inst_valid); else passed++;
        fetch_word(1, 32'hCAFE_0002, "wraplo");
    endtask

    task automatic test_random();
        logic [1:0] src;
        logic [31:0] b, j, r;
        for (int k = 0; k < 40; k++) begin
            src = 2'($urandom_range(0, 3));
            b = $urandom;
            j = $urandom;
            r = $urandom & 32'hFFFF_FFFC;
            do_advance(src, b, j, r, $urandom_range(0, 3), "rnd");
            fetch_word($urandom_range(0, 3), $urandom, "rnd");
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_pcsource();
        test_misaligned_jr();
        test_timeout();
        test_reset_mid_fetch();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
